// File: rtl/wb_result_stage.sv
// MEM/WB result stage: captures EX results, extracts load data, drives the
// register-file write port and the MEM-stage forwarding bus.
module wb_result_stage #(
  parameter int REG_AW        = 5,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [2:0]        ex_wb_sel,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_link_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              fwd_mem_valid,
  output logic [REG_AW-1:0] fwd_mem_dest,
  output logic [31:0]       fwd_mem_data,
  output logic              fwd_mem_is_load
);

  typedef enum logic [2:0] {
    SEL_ALU  = 3'd0,
    SEL_LW   = 3'd1,
    SEL_LB   = 3'd2,
    SEL_LBU  = 3'd3,
    SEL_LH   = 3'd4,
    SEL_LHU  = 3'd5,
    SEL_LINK = 3'd6,
    SEL_RSVD = 3'd7
  } wb_sel_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] dest;
    wb_sel_e           sel;
    logic [31:0]       alu;
    logic [31:0]       link;
  } mem_reg_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] dest;
    logic [31:0]       data;
  } wb_reg_t;

  mem_reg_t mem_q;
  wb_reg_t  wb_q;

  logic [1:0]  off;
  logic [1:0]  byte_idx;
  logic        half_idx;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] result;
  logic        mem_is_load;

  // flush wins over stall: with both set, the MEM occupant is dropped as well
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (flush) begin
      mem_q.valid <= 1'b0;
    end else if (!stall) begin
      mem_q <= '{valid:     ex_valid,
                 reg_write: ex_reg_write,
                 dest:      ex_dest,
                 sel:       wb_sel_e'(ex_wb_sel),
                 alu:       ex_alu_result,
                 link:      ex_link_addr};
    end
  end

  always_comb begin
    off      = mem_q.alu[1:0];
    byte_idx = LITTLE_ENDIAN ? off : ~off;
    half_idx = LITTLE_ENDIAN ? off[1] : ~off[1];
    ld_byte  = mem_rdata[{byte_idx, 3'b000} +: 8];
    ld_half  = half_idx ? mem_rdata[31:16] : mem_rdata[15:0];
    result   = mem_q.alu;
    case (mem_q.sel)
      SEL_LW:   result = mem_rdata;
      SEL_LB:   result = {{24{ld_byte[7]}}, ld_byte};
      SEL_LBU:  result = {24'h0, ld_byte};
      SEL_LH:   result = {{16{ld_half[15]}}, ld_half};
      SEL_LHU:  result = {16'h0, ld_half};
      SEL_LINK: result = mem_q.link;
      default:  result = mem_q.alu;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= '{valid: mem_q.valid,
                we:    mem_q.reg_write,
                dest:  mem_q.dest,
                data:  result};
    end
  end

  // stall gating keeps a held WB entry from writing more than once
  assign rf_we    = wb_q.valid & wb_q.we & (wb_q.dest != '0) & ~stall;
  assign rf_waddr = wb_q.dest;
  assign rf_wdata = wb_q.data;

  assign mem_is_load     = (mem_q.sel inside {SEL_LW, SEL_LB, SEL_LBU, SEL_LH, SEL_LHU});
  assign fwd_mem_valid   = mem_q.valid & mem_q.reg_write & (mem_q.dest != '0);
  assign fwd_mem_dest    = mem_q.dest;
  assign fwd_mem_data    = (mem_q.sel == SEL_LINK) ? mem_q.link : mem_q.alu;
  assign fwd_mem_is_load = fwd_mem_valid & mem_is_load;

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: directed vector table, stall/flush/reset
// sequences, and a randomized run against an in-order write scoreboard.
module tb_wb_result_stage;
  localparam int AW = 5;
  localparam bit LE = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, ex_valid, ex_reg_write;
  logic [AW-1:0] ex_dest;
  logic [2:0]    ex_wb_sel;
  logic [31:0]   ex_alu_result, ex_link_addr, mem_rdata;
  logic          rf_we, fwd_mem_valid, fwd_mem_is_load;
  logic [AW-1:0] rf_waddr, fwd_mem_dest;
  logic [31:0]   rf_wdata, fwd_mem_data;

  wb_result_stage #(.REG_AW(AW), .LITTLE_ENDIAN(LE)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
    .ex_wb_sel(ex_wb_sel), .ex_alu_result(ex_alu_result),
    .ex_link_addr(ex_link_addr), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_dest(fwd_mem_dest),
    .fwd_mem_data(fwd_mem_data), .fwd_mem_is_load(fwd_mem_is_load)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        v, rw;
    logic [2:0]  sel;
    logic [4:0]  dest;
    logic [31:0] alu, link, rd;
    logic        exp_we;
    logic [31:0] exp_data, exp_fwd;
    logic        exp_ld;
  } vec_t;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  vec_t tv[15];
  wr_t  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rw, input logic [2:0] sel,
                          input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] link);
    ex_valid = v; ex_reg_write = rw; ex_wb_sel = sel; ex_dest = dest;
    ex_alu_result = alu; ex_link_addr = link;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_we"},    32'(rf_we), 32'd0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
    chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    chk({tag, "_fwd_v"},    32'(fwd_mem_valid), 32'd0);
    chk({tag, "_fwd_dest"}, 32'(fwd_mem_dest), 32'd0);
    chk({tag, "_fwd_data"}, fwd_mem_data, 32'd0);
    chk({tag, "_fwd_ld"},   32'(fwd_mem_is_load), 32'd0);
  endtask

  function automatic vec_t mk(input logic v, input logic rw, input logic [2:0] sel,
                              input logic [4:0] dest, input logic [31:0] alu,
                              input logic [31:0] link, input logic [31:0] rd,
                              input logic exp_we, input logic [31:0] exp_data,
                              input logic [31:0] exp_fwd, input logic exp_ld);
    vec_t t;
    t.v = v; t.rw = rw; t.sel = sel; t.dest = dest; t.alu = alu; t.link = link; t.rd = rd;
    t.exp_we = exp_we; t.exp_data = exp_data; t.exp_fwd = exp_fwd; t.exp_ld = exp_ld;
    return t;
  endfunction

  // Memory model: word content depends only on the word address
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Writeback value from the load/extension rules, using plain arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] sel, input logic [31:0] alu,
                                             input logic [31:0] link, input logic [31:0] rd);
    int unsigned off, bi, hi, b, h;
    off = alu % 4;
    bi  = LE ? off : 3 - off;
    hi  = LE ? off / 2 : 1 - off / 2;
    b   = (rd >> (8 * bi)) % 256;
    h   = (rd >> (16 * hi)) % 65536;
    case (sel)
      3'd1:    return rd;
      3'd2:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd3:    return b;
      3'd4:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd6:    return link;
      default: return alu;
    endcase
  endfunction

  task automatic score_write(input string tag);
    wr_t e;
    chk({tag, "_no_write_in_stall"}, 32'(rf_we & stall), 32'd0);
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_unexpected_write"}, 32'(rf_waddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_waddr"}, 32'(rf_waddr), 32'(e.dest));
        chk({tag, "_wdata"}, rf_wdata, e.data);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mem_addr;
    mem_addr = '0;
    tv[0]  = mk(1, 1, 3'd0,  8, 32'h0000_1234, 0, 0,            1, 32'h0000_1234, 32'h0000_1234, 0);
    tv[1]  = mk(1, 1, 3'd2,  3, 32'h0000_1003, 0, 32'h80FF_1234, 1, 32'hFFFF_FF80, 32'h0000_1003, 1);
    tv[2]  = mk(1, 1, 3'd3,  4, 32'h0000_1003, 0, 32'h80FF_1234, 1, 32'h0000_0080, 32'h0000_1003, 1);
    tv[3]  = mk(1, 1, 3'd4,  5, 32'h0000_1002, 0, 32'h80FF_1234, 1, 32'hFFFF_80FF, 32'h0000_1002, 1);
    tv[4]  = mk(1, 1, 3'd5,  6, 32'h0000_1002, 0, 32'h80FF_1234, 1, 32'h0000_80FF, 32'h0000_1002, 1);
    tv[5]  = mk(1, 1, 3'd1,  7, 32'h0000_1002, 0, 32'h80FF_1234, 1, 32'h80FF_1234, 32'h0000_1002, 1);
    tv[6]  = mk(1, 1, 3'd0,  0, 32'h0000_0077, 0, 0,            0, 32'h0,         32'h0000_0077, 0);
    tv[7]  = mk(1, 1, 3'd6, 31, 32'h0000_DEAD, 32'h0040_0008, 0, 1, 32'h0040_0008, 32'h0040_0008, 0);
    tv[8]  = mk(1, 1, 3'd1,  5, 32'h0000_2000, 0, 32'h1122_3344, 1, 32'h1122_3344, 32'h0000_2000, 1);
    tv[9]  = mk(1, 1, 3'd0,  5, 32'h0000_0055, 0, 0,            1, 32'h0000_0055, 32'h0000_0055, 0);
    tv[10] = mk(1, 0, 3'd0, 12, 32'h0000_0066, 0, 0,            0, 32'h0,         32'h0000_0066, 0);
    tv[11] = mk(0, 1, 3'd1, 13, 32'h0000_0088, 0, 0,            0, 32'h0,         32'h0000_0088, 0);
    tv[12] = mk(1, 1, 3'd7, 10, 32'h0000_CAFE, 0, 0,            1, 32'h0000_CAFE, 32'h0000_CAFE, 0);
    tv[13] = mk(1, 1, 3'd2, 14, 32'h0000_1001, 0, 32'h80FF_1234, 1, 32'h0000_0012, 32'h0000_1001, 1);
    tv[14] = mk(1, 1, 3'd4, 15, 32'h0000_1001, 0, 32'h80FF_1234, 1, 32'h0000_1234, 32'h0000_1001, 1);

    // Reset state, during and just after reset
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_rdata = '0;
    drive_ex(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_held");
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_released");
    step();

    // Vector table: one instruction at a time, MEM then WB cycle checked
    for (int i = 0; i < 15; i++) begin
      drive_ex(tv[i].v, tv[i].rw, tv[i].sel, tv[i].dest, tv[i].alu, tv[i].link);
      step();
      drive_ex(0, 0, 0, 0, 0, 0);
      mem_rdata = tv[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_fwd_valid", i), 32'(fwd_mem_valid), 32'(tv[i].exp_we));
      chk($sformatf("v%0d_fwd_dest", i),  32'(fwd_mem_dest), 32'(tv[i].dest));
      chk($sformatf("v%0d_fwd_data", i),  fwd_mem_data, tv[i].exp_fwd);
      chk($sformatf("v%0d_fwd_is_load", i), 32'(fwd_mem_is_load), 32'(tv[i].exp_ld));
      chk($sformatf("v%0d_rf_we_early", i), 32'(rf_we), 32'd0);
      step();
      @(negedge clk);
      chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(tv[i].exp_we));
      if (tv[i].exp_we) begin
        chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(tv[i].dest));
        chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tv[i].exp_data);
      end
      step();
      @(negedge clk);
      chk($sformatf("v%0d_rf_we_pulse", i), 32'(rf_we), 32'd0);
      step();
    end

    // Stall for 3 cycles with a write waiting in WB
    drive_ex(1, 1, 0, 9, 32'h0000_0099, 0);
    step();
    drive_ex(0, 0, 0, 0, 0, 0);
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_rf_we", k), 32'(rf_we), 32'd0);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("stall_release_we",    32'(rf_we), 32'd1);
    chk("stall_release_waddr", 32'(rf_waddr), 32'd9);
    chk("stall_release_wdata", rf_wdata, 32'h0000_0099);
    step();
    @(negedge clk);
    chk("stall_single_pulse", 32'(rf_we), 32'd0);
    step();

    // flush together with stall drops the MEM occupant
    drive_ex(1, 1, 0, 10, 32'h0000_000A, 0);
    step();
    drive_ex(0, 0, 0, 0, 0, 0);
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("flush_stall%0d_rf_we", k), 32'(rf_we), 32'd0);
      step();
    end

    // flush alone: MEM occupant advances, the entering instruction dies
    drive_ex(1, 1, 0, 11, 32'h0000_000B, 0);
    step();
    drive_ex(1, 1, 0, 12, 32'h0000_000C, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_ex(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_older_we",    32'(rf_we), 32'd1);
    chk("flush_older_waddr", 32'(rf_waddr), 32'd11);
    chk("flush_older_wdata", rf_wdata, 32'h0000_000B);
    chk("flush_mem_killed",  32'(fwd_mem_valid), 32'd0);
    step();
    @(negedge clk);
    chk("flush_young_no_write", 32'(rf_we), 32'd0);
    step();

    // Async reset with instructions in MEM and WB
    drive_ex(1, 1, 0, 13, 32'h0000_000D, 0);
    step();
    drive_ex(1, 1, 1, 14, 32'h0000_000E, 0);
    step();
    drive_ex(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset_rf_we",  32'(rf_we), 32'd1);
    chk("pre_reset_fwd_v",  32'(fwd_mem_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d_rf_we", k), 32'(rf_we), 32'd0);
      chk($sformatf("post_reset%0d_fwd_v", k), 32'(fwd_mem_valid), 32'd0);
      step();
    end

    // Randomized run against the in-order write scoreboard
    for (int c = 0; c < 800; c++) begin
      stall         = ($urandom_range(0, 9) == 0);
      flush         = !stall && ($urandom_range(0, 11) == 0);
      ex_valid      = ($urandom_range(0, 4) != 0);
      ex_reg_write  = ($urandom_range(0, 6) != 0);
      ex_dest       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ex_wb_sel     = 3'($urandom_range(0, 7));
      ex_alu_result = $urandom;
      ex_link_addr  = $urandom;
      mem_rdata     = memfn(mem_addr);
      @(negedge clk);
      score_write("rnd");
      @(posedge clk);
      if (!stall && !flush) begin
        mem_addr = ex_alu_result;
        if (ex_valid && ex_reg_write && ex_dest != 0)
          exp_q.push_back('{dest: ex_dest,
                            data: ref_result(ex_wb_sel, ex_alu_result, ex_link_addr,
                                             memfn(ex_alu_result))});
      end
      #1;
    end

    stall = 1'b0; flush = 1'b0;
    drive_ex(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      mem_rdata = memfn(mem_addr);
      @(negedge clk);
      score_write("drain");
      step();
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
- Result-side counterpart of the EX operand-source selection: captures EX-stage results into the MEM and WB pipeline registers.
- Selects the final writeback value from the ALU result, the extended load data, or the link address.
- Drives the register-file write port and the MEM/WB forwarding buses that return to the operand muxes.
- Sits between the EX stage and the register file of the 5-stage pipeline CPU.

Parameters:
- REG_AW, 5, register address width
- LITTLE_ENDIAN, 1, byte-lane order for sub-word loads (1 = byte 0 at addr[1:0]=0; 0 = byte 0 at addr[1:0]=3)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  freeze MEM and WB registers
- flush  in  1  kill the instruction entering MEM
- ex_valid  in  1  EX holds a real instruction
- ex_reg_write  in  1  instruction writes a register
- ex_dest  in  REG_AW  destination register
- ex_wb_sel  in  3  0 ALU, 1 LW, 2 LB, 3 LBU, 4 LH, 5 LHU, 6 LINK, 7 reserved (treated as ALU)
- ex_alu_result  in  32  ALU output; also the memory address for loads
- ex_link_addr  in  32  PC+8 for jal/jalr
- mem_rdata  in  32  synchronous data-memory read word, valid during the cycle the load is in MEM
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  32  write data
- fwd_mem_valid  out  1  MEM stage will write a register
- fwd_mem_dest  out  REG_AW  MEM destination
- fwd_mem_data  out  32  ALU result or link address of the MEM instruction
- fwd_mem_is_load  out  1  MEM data not yet available; drives load-use stall upstream

Behaviour:
- Reset (async, rst_n=0): MEM and WB valid, reg_write, dest, sel and data registers clear to 0. All outputs read 0 while reset is held and after release until new data arrives.
- MEM register, at each edge:
  - flush=1: m_valid<=0, other fields don't-care. flush has priority over stall.
  - else stall=1: hold.
  - else: capture all ex_* fields.
- WB register, at each edge:
  - stall=1: hold.
  - else: w_valid<=m_valid, w_dest<=m_dest, w_we<=m_reg_write, w_data<=selected result.
- Result select, combinational in MEM, using m_alu_result[1:0] as offset:
  - ALU: alu_result.
  - LINK: link_addr.
  - LW: mem_rdata.
  - LB/LBU: byte chosen by offset per LITTLE_ENDIAN; sign-/zero-extend to 32.
  - LH/LHU: half chosen by offset[1] (offset[0] ignored, no alignment trap); sign-/zero-extend.
- rf_we = w_valid & w_we & (w_dest != 0) & ~stall. rf_waddr=w_dest, rf_wdata=w_data. Gating on stall guarantees exactly one write per instruction.
- Writes to register 0 are never issued.
- Latency: ex_* sampled at edge N; rf_we high for the cycle after edge N+1, with no stalls. Each stall cycle adds one cycle.
- fwd_mem_valid = m_valid & m_reg_write & (m_dest != 0).
- fwd_mem_data = link_addr if sel=LINK, else alu_result.
- fwd_mem_is_load = fwd_mem_valid & (sel in 1..5).
- The WB forward path is the rf_* outputs themselves.
- Memory holds mem_rdata stable during stall; this block does not buffer it.
- Reset asserted mid-operation discards all in-flight instructions immediately; no write is issued.
- Bubble (ex_valid=0) propagates with valid=0; rf_we stays 0.

Test Plan:
- ALU path: ex_valid=1, dest=8, sel=0, alu_result=0x0000_1234, no stall -> rf_we=1, rf_waddr=8, rf_wdata=0x1234 exactly two edges later, for one cycle.
- Loads with alu_result=0x1003, mem_rdata=0x80FF_1234, LITTLE_ENDIAN=1:
  - LB -> 0xFFFF_FF80; LBU -> 0x0000_0080.
  - With alu_result=0x1002: LH -> 0xFFFF_80FF; LHU -> 0x0000_80FF; LW -> 0x80FF_1234.
- Register-0 suppression and link: dest=0, sel=0 -> rf_we never asserts. dest=31, sel=6, link_addr=0x0040_0008 -> rf_wdata=0x0040_0008; fwd_mem_data=0x0040_0008 while in MEM.
- Stall/flush:
  - stall=1 for 3 cycles while a write sits in WB -> rf_we=0 during stall, exactly one write pulse after release.
  - flush=1 together with stall=1 -> MEM instruction discarded; its write never appears.
- Forwarding/hazard: LW dest=5 in MEM -> fwd_mem_valid=1, fwd_mem_is_load=1; ADD dest=5 in MEM -> fwd_mem_is_load=0, fwd_mem_data=alu_result.
- Async reset: drop rst_n mid-cycle with instructions in MEM and WB -> all outputs 0 immediately, no write after release until new ex_valid.
